// File: rtl/half_adder.sv
// Multi-lane half adder with a combinational path and a registered,
// valid-qualified path carrying saturating operation and carry counters.
module half_adder #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] cout,
   output logic [WIDTH-1:0] sum_q,
   output logic [WIDTH-1:0] cout_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] carry_count
);

   localparam logic [CNT_W-1:0] cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] cnt_max = '1;

   logic op_sat;
   logic carry_sat;
   logic any_carry;

   assign sum  = a ^ b;
   assign cout = a & b;

   assign any_carry = |cout;
   assign op_sat    = (op_count == cnt_max);
   assign carry_sat = (carry_count == cnt_max);

   // Counters see the same operands as the sum_q/cout_q capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= '0;
         cout_q      <= '0;
         out_valid   <= 1'b0;
         op_count    <= '0;
         carry_count <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum_q  <= sum;
            cout_q <= cout;
            if (!op_sat)
               op_count <= op_count + cnt_one;
            if (any_carry && !carry_sat)
               carry_count <= carry_count + cnt_one;
         end
      end
   end

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: directed vectors plus random traffic on a
// 1-lane/16-bit-counter instance and a 4-lane/4-bit-counter instance.
module tb_half_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       a1, b1, v1;
   logic [3:0] a4, b4;
   logic       v4;

   logic        sum1, cout1, sq1, cq1, ov1;
   logic [15:0] op1, cc1;
   logic [3:0]  sum4, cout4, sq4, cq4;
   logic        ov4;
   logic [3:0]  op4, cc4;

   int errs   = 0;
   int checks = 0;

   half_adder #(.WIDTH(1), .CNT_W(16)) u_w1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
      .sum(sum1), .cout(cout1), .sum_q(sq1), .cout_q(cq1),
      .out_valid(ov1), .op_count(op1), .carry_count(cc1)
   );

   half_adder #(.WIDTH(4), .CNT_W(4)) u_w4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
      .sum(sum4), .cout(cout4), .sum_q(sq4), .cout_q(cq4),
      .out_valid(ov4), .op_count(op4), .carry_count(cc4)
   );

   always #5 clk = ~clk;

   // Reference state
   logic       m1_s, m1_c, m1_v;
   int         m1_op, m1_cc;
   logic [3:0] m4_s, m4_c;
   logic       m4_v;
   int         m4_op, m4_cc;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Lane-wise arithmetic: the two-bit sum of a and b per lane.
   function automatic void add_lanes(input logic [3:0] x, input logic [3:0] y,
                                     input int w, output logic [3:0] s,
                                     output logic [3:0] c);
      s = '0;
      c = '0;
      for (int i = 0; i < w; i++) begin
         int t;
         t = int'(x[i]) + int'(y[i]);
         s[i] = (t % 2) == 1;
         c[i] = (t / 2) == 1;
      end
   endfunction

   function automatic int sat_inc(input int v, input int maxv);
      return (v + 1 > maxv) ? maxv : v + 1;
   endfunction

   task automatic model_edge();
      logic [3:0] s, c;
      if (rst) begin
         m1_s = 0; m1_c = 0; m1_v = 0; m1_op = 0; m1_cc = 0;
         m4_s = 0; m4_c = 0; m4_v = 0; m4_op = 0; m4_cc = 0;
      end else begin
         m1_v = v1;
         if (v1) begin
            add_lanes({3'b0, a1}, {3'b0, b1}, 1, s, c);
            m1_s = s[0];
            m1_c = c[0];
            m1_op = sat_inc(m1_op, 65535);
            if (c != 0) m1_cc = sat_inc(m1_cc, 65535);
         end
         m4_v = v4;
         if (v4) begin
            add_lanes(a4, b4, 4, s, c);
            m4_s = s;
            m4_c = c;
            m4_op = sat_inc(m4_op, 15);
            if (c != 0) m4_cc = sat_inc(m4_cc, 15);
         end
      end
   endtask

   task automatic check_comb();
      logic [3:0] s, c;
      add_lanes({3'b0, a1}, {3'b0, b1}, 1, s, c);
      check("sum1", 64'(sum1), 64'(s[0]));
      check("cout1", 64'(cout1), 64'(c[0]));
      add_lanes(a4, b4, 4, s, c);
      check("sum4", 64'(sum4), 64'(s));
      check("cout4", 64'(cout4), 64'(c));
   endtask

   task automatic check_all();
      check_comb();
      check("sum_q1", 64'(sq1), 64'(m1_s));
      check("cout_q1", 64'(cq1), 64'(m1_c));
      check("out_valid1", 64'(ov1), 64'(m1_v));
      check("op_count1", 64'(op1), 64'(m1_op));
      check("carry_count1", 64'(cc1), 64'(m1_cc));
      check("sum_q4", 64'(sq4), 64'(m4_s));
      check("cout_q4", 64'(cq4), 64'(m4_c));
      check("out_valid4", 64'(ov4), 64'(m4_v));
      check("op_count4", 64'(op4), 64'(m4_op));
      check("carry_count4", 64'(cc4), 64'(m4_cc));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   logic [1:0] ab_vec [4];
   logic [1:0] sc_vec [4];

   initial begin
      ab_vec = '{2'b00, 2'b01, 2'b10, 2'b11};
      sc_vec = '{2'b00, 2'b10, 2'b10, 2'b01};
      rst = 1; v1 = 1; v4 = 1;
      a1 = 1; b1 = 1; a4 = '1; b4 = '1;
      m1_s = 0; m1_c = 0; m1_v = 0; m1_op = 0; m1_cc = 0;
      m4_s = 0; m4_c = 0; m4_v = 0; m4_op = 0; m4_cc = 0;
      cyc();
      cyc();
      check("rst_op4", 64'(op4), 64'd0);
      check("rst_ov1", 64'(ov1), 64'd0);

      // Combinational truth table, still in reset
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab, sc;
         ab = ab_vec[i];
         sc = sc_vec[i];
         a1 = ab[1];
         b1 = ab[0];
         #1;
         check("tt_sum", 64'(sum1), 64'(sc[1]));
         check("tt_cout", 64'(cout1), 64'(sc[0]));
      end
      v1 = 0; v4 = 0;
      cyc();

      // Release; 4-lane single operation
      rst = 0;
      a4 = 4'b1100; b4 = 4'b1010; v4 = 1;
      cyc();
      check("w4_sum_q", 64'(sq4), 64'h6);
      check("w4_cout_q", 64'(cq4), 64'h8);
      check("w4_ov", 64'(ov4), 64'd1);
      check("w4_op", 64'(op4), 64'd1);
      check("w4_cc", 64'(cc4), 64'd1);
      v4 = 0;

      // Back-to-back on 1 lane
      v1 = 1;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = ab_vec[i];
         a1 = ab[1];
         b1 = ab[0];
         cyc();
         check("b2b_ov", 64'(ov1), 64'd1);
      end
      check("b2b_op", 64'(op1), 64'd4);
      check("b2b_cc", 64'(cc1), 64'd1);
      check("b2b_sq", 64'(sq1), 64'd0);
      check("b2b_cq", 64'(cq1), 64'd1);

      // Idle hold
      v1 = 0;
      a1 = 0; b1 = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("idle_ov", 64'(ov1), 64'd0);
         check("idle_cq", 64'(cq1), 64'd1);
         check("idle_op", 64'(op1), 64'd4);
      end

      // Reset coincident with a valid op
      rst = 1; v1 = 1; v4 = 1;
      a1 = 1; b1 = 1; a4 = 4'b0110; b4 = 4'b0011;
      cyc();
      check("rstv_op1", 64'(op1), 64'd0);
      check("rstv_cq1", 64'(cq1), 64'd0);
      check("rstv_ov4", 64'(ov4), 64'd0);
      check("rstv_sum4", 64'(sum4), 64'h5);
      check("rstv_cout4", 64'(cout4), 64'h2);

      // Saturation on 4-bit counters, first post-reset cycle accepted
      rst = 0; v1 = 0; v4 = 1;
      a4 = 4'b1111; b4 = 4'b1111;
      cyc();
      check("first_op4", 64'(op4), 64'd1);
      for (int i = 1; i < 20; i++) cyc();
      check("sat_op4", 64'(op4), 64'd15);
      check("sat_cc4", 64'(cc4), 64'd15);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 31) == 0);
         v1 = $urandom_range(0, 3) != 0;
         v4 = $urandom_range(0, 3) != 0;
         a1 = 1'($urandom);
         b1 = 1'($urandom);
         a4 = 4'($urandom);
         b4 = 4'($urandom);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
